// File: rtl/qspi_master.sv
// Quad-SPI master: turns one 1-4 byte memory request into a nibble stream toward
// a continuous-read flash or one of two PSRAMs, and returns read data plus a done pulse.
module qspi_master (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_is_write,
  input  logic [1:0]  i_target,
  input  logic [23:0] i_addr,
  input  logic [1:0]  i_len,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_err,
  output logic        o_qspi_clk,
  output logic        o_qspi_flash_select,
  output logic        o_qspi_ram_a_select,
  output logic        o_qspi_ram_b_select,
  output logic [3:0]  o_qspi_data_out,
  output logic [3:0]  o_qspi_data_oe,
  input  logic [3:0]  i_qspi_data_in
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_MODE  = 3'd3,
    S_DUMMY = 3'd4,
    S_DATA  = 3'd5,
    S_DESEL = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_is_write;
  logic        r_is_flash;
  logic [23:0] r_addr;
  logic [1:0]  r_len;
  logic [31:0] r_wdata;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_err;
  logic        r_qspi_clk;
  logic [2:0]  r_sel;
  logic [3:0]  r_data_out;
  logic [3:0]  r_data_oe;

  logic        w_reject;
  state_t      w_first;
  logic [5:0]  w_nxt;
  state_t      w_nstate;
  logic [2:0]  w_ncnt;
  logic [31:0] w_sample;

  // Nibble driven for position cnt of a given phase.
  function automatic logic [3:0] f_nib(input state_t st, input logic [2:0] cnt,
                                       input logic is_write, input logic [23:0] addr,
                                       input logic [31:0] wdata);
    logic [7:0]  cmd;
    logic [23:0] ash;
    logic [31:0] wsh;
    logic [3:0]  nib;
    cmd = is_write ? 8'h02 : 8'h0B;
    ash = addr >> (5'd20 - {cnt, 2'b00});
    wsh = wdata >> {cnt[2:1], ~cnt[0], 2'b00};
    nib = 4'h0;
    case (st)
      S_CMD:   nib = (cnt == 3'd0) ? cmd[7:4] : cmd[3:0];
      S_ADDR:  nib = ash[3:0];
      S_MODE:  nib = (cnt == 3'd0) ? 4'hA : 4'h0;
      S_DATA:  nib = is_write ? wsh[3:0] : 4'h0;
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  function automatic logic f_oe(input state_t st, input logic is_write);
    logic oe;
    case (st)
      S_CMD, S_ADDR, S_MODE: oe = 1'b1;
      S_DATA:                oe = is_write;
      default:               oe = 1'b0;
    endcase
    return oe;
  endfunction

  // Successor {state, count} after the nibble at (st, cnt); empty phases are skipped.
  function automatic logic [5:0] f_next(input state_t st, input logic [2:0] cnt,
                                        input logic is_write, input logic is_flash,
                                        input logic [1:0] len);
    logic [5:0] nx;
    nx = {S_DESEL, 3'd0};
    case (st)
      S_CMD: begin
        if (cnt == 3'd1) nx = {S_ADDR, 3'd0};
        else             nx = {S_CMD, cnt + 3'd1};
      end
      S_ADDR: begin
        if (cnt != 3'd5)  nx = {S_ADDR, cnt + 3'd1};
        else if (is_flash) nx = {S_MODE, 3'd0};
        else if (is_write) nx = {S_DATA, 3'd0};
        else               nx = {S_DUMMY, 3'd0};
      end
      S_MODE: begin
        if (cnt == 3'd1) nx = {S_DUMMY, 3'd0};
        else             nx = {S_MODE, cnt + 3'd1};
      end
      S_DUMMY: begin
        if (cnt == 3'd3) nx = {S_DATA, 3'd0};
        else             nx = {S_DUMMY, cnt + 3'd1};
      end
      S_DATA: begin
        if (cnt == {len, 1'b1}) nx = {S_DESEL, 3'd0};
        else                    nx = {S_DATA, cnt + 3'd1};
      end
      default: nx = {S_DESEL, 3'd0};
    endcase
    return nx;
  endfunction

  assign w_reject = (i_target == 2'd3) || ((i_target == 2'd0) && i_is_write);
  assign w_first  = (i_target == 2'd0) ? S_ADDR : S_CMD;
  assign w_nxt    = f_next(r_state, r_cnt, r_is_write, r_is_flash, r_len);
  assign w_nstate = state_t'(w_nxt[5:3]);
  assign w_ncnt   = w_nxt[2:0];
  // Read byte k lands in rdata[8k+7:8k], high nibble received first.
  assign w_sample = {28'd0, i_qspi_data_in} << {r_cnt[2:1], ~r_cnt[0], 2'b00};

  // Sequencer: request capture, nibble phases, read assembly and completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_is_write <= 1'b0;
      r_is_flash <= 1'b0;
      r_addr     <= 24'd0;
      r_len      <= 2'd0;
      r_wdata    <= 32'd0;
      r_ready    <= 1'b1;
      r_rdata    <= 32'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_qspi_clk <= 1'b0;
      r_sel      <= 3'b111;
      r_data_out <= 4'h0;
      r_data_oe  <= 4'h0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_is_write <= i_is_write;
            r_is_flash <= (i_target == 2'd0);
            r_addr     <= i_addr;
            r_len      <= i_len;
            r_wdata    <= i_wdata;
            r_ready    <= 1'b0;
            r_cnt      <= 3'd0;
            if (w_reject) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state    <= w_first;
              r_qspi_clk <= 1'b0;
              r_data_out <= f_nib(w_first, 3'd0, i_is_write, i_addr, i_wdata);
              r_data_oe  <= {4{f_oe(w_first, i_is_write)}};
              case (i_target)
                2'd0:    r_sel <= 3'b110;
                2'd1:    r_sel <= 3'b101;
                2'd2:    r_sel <= 3'b011;
                default: r_sel <= 3'b111;
              endcase
              if (!i_is_write) begin
                r_rdata <= 32'd0;
              end
            end
          end
        end
        S_ERR, S_DESEL: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          if (!r_qspi_clk) begin
            r_qspi_clk <= 1'b1;
            if ((r_state == S_DATA) && !r_is_write) begin
              r_rdata <= r_rdata | w_sample;
            end
          end else begin
            r_qspi_clk <= 1'b0;
            r_state    <= w_nstate;
            r_cnt      <= w_ncnt;
            if (w_nstate == S_DESEL) begin
              r_sel      <= 3'b111;
              r_data_out <= 4'h0;
              r_data_oe  <= 4'h0;
              r_done     <= 1'b1;
            end else begin
              r_data_out <= f_nib(w_nstate, w_ncnt, r_is_write, r_addr, r_wdata);
              r_data_oe  <= {4{f_oe(w_nstate, r_is_write)}};
            end
          end
        end
      endcase
    end
  end

  assign o_ready             = r_ready;
  assign o_rdata             = r_rdata;
  assign o_done              = r_done;
  assign o_err               = r_err;
  assign o_qspi_clk          = r_qspi_clk;
  assign o_qspi_flash_select = r_sel[0];
  assign o_qspi_ram_a_select = r_sel[1];
  assign o_qspi_ram_b_select = r_sel[2];
  assign o_qspi_data_out     = r_data_out;
  assign o_qspi_data_oe      = r_data_oe;

endmodule

// File: tb/tb_qspi_master.sv
// Bench for qspi_master: directed table plus random requests, with a bus-level
// slave (flash pattern, two RAM arrays) and a rule-based reference model.
module tb_qspi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_write;
  logic [1:0]  target;
  logic [23:0] addr;
  logic [1:0]  len;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        qclk;
  logic        sel_f;
  logic        sel_a;
  logic        sel_b;
  logic [3:0]  dout;
  logic [3:0]  doe;
  logic [3:0]  din;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] slave_ram [0:1][0:511];
  logic [7:0] ref_ram   [0:1][0:511];

  localparam logic [14:0] IDLE_V  = {1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 4'h0, 4'h0};
  localparam logic [14:0] DESEL_V = {1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 4'h0, 4'h0};
  localparam logic [14:0] ERR_V   = {1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 4'h0, 4'h0};

  typedef struct {
    logic        is_write;
    logic [1:0]  target;
    logic [23:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_n;
    logic [31:0] exp_rdata;
  } vec_t;

  qspi_master dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_is_write(is_write),
    .i_target(target), .i_addr(addr), .i_len(len), .i_wdata(wdata),
    .o_ready(ready), .o_rdata(rdata), .o_done(done), .o_err(err),
    .o_qspi_clk(qclk), .o_qspi_flash_select(sel_f), .o_qspi_ram_a_select(sel_a),
    .o_qspi_ram_b_select(sel_b), .o_qspi_data_out(dout), .o_qspi_data_oe(doe),
    .i_qspi_data_in(din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] flash_byte(input int a);
    logic [7:0] t;
    t = 8'(a * 3);
    return t ^ 8'h6A;
  endfunction

  function automatic logic [14:0] act_vec();
    return {ready, done, err, qclk, sel_b, sel_a, sel_f, dout, doe};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: error decision, nibble count and read data from the rules.
  task automatic model_fill(inout vec_t v);
    int idx;
    v.exp_err   = (v.target == 2'd3) || (v.target == 2'd0 && v.is_write);
    v.exp_n     = 0;
    v.exp_rdata = 32'd0;
    if (!v.exp_err) begin
      if (v.target == 2'd0) v.exp_n = 6 + 2 + 4;
      else if (v.is_write)  v.exp_n = 2 + 6;
      else                  v.exp_n = 2 + 6 + 4;
      v.exp_n += 2 * (int'(v.len) + 1);
      for (int k = 0; k <= int'(v.len); k++) begin
        idx = (int'(v.addr) + k) & 511;
        if (v.is_write)
          ref_ram[int'(v.target) - 1][idx] = v.wdata[8*k +: 8];
        else if (v.target == 2'd0)
          v.exp_rdata[8*k +: 8] = flash_byte(int'(v.addr) + k);
        else
          v.exp_rdata[8*k +: 8] = ref_ram[int'(v.target) - 1][idx];
      end
    end
  endtask

  // Runs one request cycle by cycle; optional reset or stray start at a given cycle.
  task automatic do_txn(input vec_t v, input int rst_at, input int glitch_at);
    logic [3:0]  nib_q [$];
    logic        oe_q  [$];
    logic [7:0]  cmd;
    logic [7:0]  b;
    logic [2:0]  sel_e;
    logic [14:0] e;
    int nb, dstart, n, ph, j, k, idx;
    if (v.target != 2'd0) begin
      cmd = v.is_write ? 8'h02 : 8'h0B;
      nib_q.push_back(cmd[7:4]); oe_q.push_back(1'b1);
      nib_q.push_back(cmd[3:0]); oe_q.push_back(1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      nib_q.push_back(v.addr[23 - 4*i -: 4]); oe_q.push_back(1'b1);
    end
    if (v.target == 2'd0) begin
      nib_q.push_back(4'hA); oe_q.push_back(1'b1);
      nib_q.push_back(4'h0); oe_q.push_back(1'b1);
    end
    if (!v.is_write) begin
      for (int i = 0; i < 4; i++) begin
        nib_q.push_back(4'h0); oe_q.push_back(1'b0);
      end
    end
    for (int i = 0; i <= int'(v.len); i++) begin
      b = v.is_write ? v.wdata[8*i +: 8] : 8'h00;
      nib_q.push_back(b[7:4]); oe_q.push_back(v.is_write);
      nib_q.push_back(b[3:0]); oe_q.push_back(v.is_write);
    end
    sel_e = (v.target == 2'd0) ? 3'b110 : (v.target == 2'd1) ? 3'b101 : 3'b011;
    nb = nib_q.size();
    dstart = nb - 2 * (int'(v.len) + 1);

    chk("ready_c0", {31'd0, ready}, 32'd1);
    start = 1'b1; is_write = v.is_write; target = v.target;
    addr = v.addr; len = v.len; wdata = v.wdata;
    @(negedge clk);
    start = 1'b0;
    if (v.exp_err) begin
      chk("err_c1", {17'd0, act_vec()}, {17'd0, ERR_V});
      @(negedge clk);
      chk("err_c2", {17'd0, act_vec()}, {17'd0, IDLE_V});
      return;
    end
    for (int c = 1; c <= 2 * v.exp_n + 2; c++) begin
      din = 4'h0;
      if (c <= 2 * v.exp_n) begin
        n = (c - 1) / 2;
        ph = (c - 1) % 2;
        e = {3'b000, ph[0], sel_e, (n < nb) ? nib_q[n] : 4'h0,
             (n < nb && oe_q[n]) ? 4'hF : 4'h0};
        chk($sformatf("bus t%0d c%0d", v.target, c), {17'd0, act_vec()}, {17'd0, e});
        if (n >= dstart) begin
          j = n - dstart; k = j / 2; idx = (int'(v.addr) + k) & 511;
          if (!v.is_write && ph == 0) begin
            b = (v.target == 2'd0) ? flash_byte(int'(v.addr) + k)
                                   : slave_ram[int'(v.target) - 1][idx];
            din = (j % 2 == 0) ? b[7:4] : b[3:0];
          end else if (v.is_write && ph == 1) begin
            if (j % 2 == 0) slave_ram[int'(v.target) - 1][idx][7:4] = dout;
            else            slave_ram[int'(v.target) - 1][idx][3:0] = dout;
          end
        end
      end else if (c == 2 * v.exp_n + 1) begin
        chk($sformatf("desel c%0d", c), {17'd0, act_vec()}, {17'd0, DESEL_V});
        if (!v.is_write) chk("rdata", rdata, v.exp_rdata);
      end else begin
        chk($sformatf("ready c%0d", c), {17'd0, act_vec()}, {17'd0, IDLE_V});
      end
      if (c == glitch_at) begin
        start = 1'b1; target = 2'd2; is_write = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_vec", {17'd0, act_vec()}, {17'd0, IDLE_V});
        chk("rst_rdata", rdata, 32'd0);
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    din = 4'h0;
  endtask

  task automatic idle_check(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk(name, {17'd0, act_vec()}, {17'd0, IDLE_V});
      @(negedge clk);
    end
  endtask

  vec_t tbl [9];
  vec_t v;
  vec_t tmp;

  initial begin
    rst = 1'b1; start = 1'b0; is_write = 1'b0; target = 2'd0;
    addr = 24'd0; len = 2'd0; wdata = 32'd0; din = 4'h0;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 512; i++) begin
        slave_ram[t][i] = 8'h00;
        ref_ram[t][i]   = 8'h00;
      end
    end
    //            wr    tgt    addr          len   wdata         err   N   rdata
    tbl[0] = '{1'b0, 2'd0, 24'h000010, 2'd0, 32'h0,        1'b0, 14, 32'h0000005A};
    tbl[1] = '{1'b1, 2'd1, 24'h000100, 2'd3, 32'h11223344, 1'b0, 16, 32'h0};
    tbl[2] = '{1'b0, 2'd1, 24'h000100, 2'd3, 32'h0,        1'b0, 20, 32'h11223344};
    tbl[3] = '{1'b1, 2'd2, 24'h000100, 2'd3, 32'hCAFEBABE, 1'b0, 16, 32'h0};
    tbl[4] = '{1'b0, 2'd2, 24'h000100, 2'd3, 32'h0,        1'b0, 20, 32'hCAFEBABE};
    tbl[5] = '{1'b0, 2'd1, 24'h000100, 2'd3, 32'h0,        1'b0, 20, 32'h11223344};
    tbl[6] = '{1'b1, 2'd0, 24'h000020, 2'd1, 32'h5555,     1'b1, 0,  32'h0};
    tbl[7] = '{1'b0, 2'd3, 24'h000030, 2'd0, 32'h0,        1'b1, 0,  32'h0};
    tbl[8] = '{1'b1, 2'd3, 24'h000040, 2'd2, 32'h0,        1'b1, 0,  32'h0};

    repeat (2) @(negedge clk);
    chk("reset_vec", {17'd0, act_vec()}, {17'd0, IDLE_V});
    chk("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      tmp = tbl[i];
      model_fill(tmp);
      do_txn(tbl[i], -1, -1);
    end

    // Reset in cycle 9 of a RAM read, then a flash read must still work.
    v = '{1'b0, 2'd1, 24'h000100, 2'd3, 32'h0, 1'b0, 20, 32'h11223344};
    do_txn(v, 9, -1);
    idle_check("post_rst_idle", 3);
    do_txn(tbl[0], -1, -1);

    // Start together with reset is dropped.
    rst = 1'b1; start = 1'b1; target = 2'd1; is_write = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    idle_check("rst_start_idle", 4);

    // Start while busy is ignored.
    v = '{1'b0, 2'd0, 24'h0000F3, 2'd2, 32'h0, 1'b0, 0, 32'h0};
    model_fill(v);
    do_txn(v, -1, 5);
    idle_check("busy_start_idle", 4);

    for (int i = 0; i < 40; i++) begin
      v.is_write = 1'($urandom_range(0, 1));
      v.target   = 2'($urandom_range(0, 3));
      v.addr     = 24'($urandom);
      v.len      = 2'($urandom_range(0, 3));
      v.wdata    = $urandom;
      model_fill(v);
      do_txn(v, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
